fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer.sv | 216 +++++++++++++++++++++
 tb/tb_fifo_rd_packer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops bytes from the read side of an async FIFO and packs
// them, lane 0 first, into 32-bit words on a valid/ready output stream.
// A flush (external pulse, or the idle timeout when enabled) emits whatever
// partial word is held, marked with m_last, then pulses flush_done.
//
// Optional build macro: FIFO_RD_PACK_TIMEOUT_EN enables an idle counter that
// flushes a partial word after TIMEOUT idle cycles.
//
// Ports:
//   rclk, rrst_n        clock / async active-low reset (FIFO read domain)
//   rd, empty, Rdata    FIFO pop request, empty flag, data (1 cycle after pop)
//   flush               single-cycle request to emit a partial word
//   m_valid, m_ready    output handshake
//   m_data, m_keep      packed word and per-byte lane valid
//   m_last              word produced by a flush
//   flush_done          one-cycle pulse when a flush completes

// One byte lane of the word buffer.
module fifo_rd_packer_lane (
  input  logic       rclk,
  input  logic       rrst_n,
  input  logic       clr,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)  q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module fifo_rd_packer #(
  parameter int TIMEOUT = 16
) (
  input  logic        rclk,
  input  logic        rrst_n,
  output logic        rd,
  input  logic        empty,
  input  logic [7:0]  Rdata,
  input  logic        flush,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_last,
  output logic        flush_done
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {FILL, HOLD, FLUSH} state_t;

  state_t                        state, n_state;
  logic [2:0]                    cnt, n_cnt;      // bytes landed in the buffer (0..4)
  logic                          inflight;        // popped byte due on Rdata this cycle
  logic                          pend, n_pend;    // flush seen, waiting for the word in HOLD
  logic                          rdy;             // low for the first edge after reset
  logic                          n_mv, n_last, n_fd;
  logic [31:0]                   n_data;
  logic [3:0]                    n_keep, part_keep;
  logic                          out_free, flush_req, tmo_fire;
  logic [NUM_LANES-1:0][7:0]     lane_q;
  logic [NUM_LANES-1:0]          lane_we;
  logic                          buf_clr;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      fifo_rd_packer_lane u_lane (
        .rclk  (rclk),
        .rrst_n(rrst_n),
        .clr   (buf_clr),
        .we    (lane_we[g]),
        .d     (Rdata),
        .q     (lane_q[g])
      );
    end
  endgenerate

`ifdef FIFO_RD_PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          idle;

  // Idle = partial word parked, nothing in flight, nothing to pop.
  assign idle     = (state == FILL) && (cnt != 3'd0) && !inflight && empty && !pend;
  assign tmo_fire = idle && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)                     tmo_cnt <= '0;
    else if (!idle || rd || tmo_fire) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo_fire       = 1'b0;
`endif

  assign out_free  = !m_valid || m_ready;
  // A flush arriving while already flushing is dropped.
  assign flush_req = (flush && (state != FLUSH)) || tmo_fire;

  // Pop only while collecting, with room for the byte in flight plus this one.
  assign rd = rdy && !empty && (state == FILL) && !pend && !flush_req &&
              ((cnt + {2'b00, inflight}) <= 3'd3);

  always_comb begin
    case (cnt)
      3'd1:    part_keep = 4'h1;
      3'd2:    part_keep = 4'h3;
      3'd3:    part_keep = 4'h7;
      default: part_keep = 4'hF;
    endcase
  end

  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_pend  = pend;
    n_mv    = m_valid && !m_ready;
    n_data  = m_data;
    n_keep  = m_keep;
    n_last  = m_last;
    n_fd    = 1'b0;
    lane_we = '0;
    buf_clr = 1'b0;

    if (state == HOLD) begin
      if (out_free) begin
        n_mv    = 1'b1;
        n_data  = lane_q;
        n_keep  = 4'hF;
        n_last  = 1'b0;
        n_cnt   = 3'd0;
        buf_clr = 1'b1;
        n_state = FILL;
      end
      if (flush_req) n_pend = 1'b1;
    end else begin
      // Landing byte; the 4th goes straight to the output when it can.
      if (inflight) begin
        if (cnt == 3'd3) begin
          if (out_free) begin
            n_mv    = 1'b1;
            n_data  = {Rdata, lane_q[2], lane_q[1], lane_q[0]};
            n_keep  = 4'hF;
            n_last  = 1'b0;
            n_cnt   = 3'd0;
            buf_clr = 1'b1;
          end else begin
            lane_we[3] = 1'b1;
            n_cnt      = 3'd4;
            n_state    = HOLD;
          end
        end else begin
          lane_we[cnt[1:0]] = 1'b1;
          n_cnt             = cnt + 3'd1;
        end
      end

      if ((state == FLUSH) || flush_req || pend) begin
        if (n_state == HOLD) begin
          n_pend = 1'b1;                    // finish the full word first
        end else if (inflight) begin
          n_state = FLUSH;                  // wait for the last byte to land
          n_pend  = 1'b0;
        end else if (cnt == 3'd0) begin
          n_fd    = 1'b1;
          n_state = FILL;
          n_pend  = 1'b0;
        end else if (out_free) begin
          // Lanes above cnt are already zero: the buffer clears on every unload.
          n_mv    = 1'b1;
          n_data  = lane_q;
          n_keep  = part_keep;
          n_last  = 1'b1;
          n_cnt   = 3'd0;
          buf_clr = 1'b1;
          n_state = FLUSH;                  // flush_done on the following cycle
          n_pend  = 1'b0;
        end else begin
          n_state = FLUSH;
          n_pend  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state      <= FILL;
      cnt        <= '0;
      inflight   <= 1'b0;
      pend       <= 1'b0;
      rdy        <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
      m_last     <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= n_state;
      cnt        <= n_cnt;
      inflight   <= rd;
      pend       <= n_pend;
      rdy        <= 1'b1;
      m_valid    <= n_mv;
      m_data     <= n_data;
      m_keep     <= n_keep;
      m_last     <= n_last;
      flush_done <= n_fd;
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;
  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        rd;
  logic        empty;
  logic [7:0]  Rdata;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        flush_done;

  fifo_rd_packer #(.TIMEOUT(16)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rd        (rd),
    .empty     (empty),
    .Rdata     (Rdata),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
    .flush_done(flush_done)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  int          nchk = 0, nerr = 0;
  int          fd_cnt = 0, exp_fd = 0, pop_cnt = 0;
  logic [7:0]  fifo[$];
  word_t       exp_q[$];
  logic [7:0]  acc[4];
  int          acc_n = 0;
  logic        hold_p = 1'b0;
  logic [36:0] hold_w = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // FIFO model push plus packing reference model.
  task automatic push(input logic [7:0] b);
    word_t w;
    fifo.push_back(b);
    empty = 1'b0;
    acc[acc_n] = b;
    acc_n++;
    if (acc_n == 4) begin
      w.d = {acc[3], acc[2], acc[1], acc[0]};
      w.k = 4'hF;
      w.l = 1'b0;
      exp_q.push_back(w);
      acc_n = 0;
    end
  endtask

  task automatic flush_model();
    word_t w;
    if (acc_n > 0) begin
      w.d = '0;
      w.k = '0;
      for (int i = 0; i < acc_n; i++) begin
        w.d[8*i +: 8] = acc[i];
        w.k[i]        = 1'b1;
      end
      w.l = 1'b1;
      exp_q.push_back(w);
    end
    acc_n = 0;
    exp_fd++;
  endtask

  task automatic pulse_flush();
    @(posedge rclk); #1;
    flush = 1'b1;
    flush_model();
    @(posedge rclk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    int i = 0;
    while ((exp_q.size() != 0 || fifo.size() != 0) && i < lim) begin
      @(posedge rclk);
      i++;
    end
    if (exp_q.size() != 0 || fifo.size() != 0) chk("drain_timeout", 0, 1);
    repeat (4) @(posedge rclk);
    #1;
  endtask

  // FIFO read side: data appears one cycle after an accepted pop.
  initial begin
    logic p;
    empty = 1'b1;
    Rdata = '0;
    forever begin
      @(negedge rclk);
      p = rd && !empty;
      @(posedge rclk); #1;
      if (p && fifo.size() > 0) begin
        Rdata = fifo.pop_front();
        pop_cnt++;
      end
      empty = (fifo.size() == 0);
    end
  end

  // Output monitor / scoreboard.
  always @(negedge rclk) begin
    word_t e;
    if (!rrst_n) begin
      hold_p = 1'b0;
    end else begin
      if (rd && empty) chk("rd_while_empty", 1, 0);
      if (hold_p) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_word", {m_last, m_keep, m_data}, hold_w);
      end
      if (flush_done) fd_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_keep", m_keep, e.k);
          chk("m_last", m_last, e.l);
        end
      end
      hold_p = m_valid && !m_ready;
      hold_w = {m_last, m_keep, m_data};
    end
  end

  initial begin
    int c0;
    rrst_n  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_rd", rd, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_keep", m_keep, 0);
    chk("rst_last", m_last, 0);
    chk("rst_fd", flush_done, 0);
    rrst_n = 1'b1;
    repeat (2) @(posedge rclk);
    #1;

    // Basic full word.
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_drain(50);

    // Sustained throughput: 16 pops in any 20-cycle window.
    for (int i = 0; i < 40; i++) push(8'(i + 8'h80));
    repeat (6) @(posedge rclk);
    #3;
    c0 = pop_cnt;
    repeat (20) @(posedge rclk);
    #3;
    chk("thru_pops", pop_cnt - c0, 16);
    wait_drain(100);

    // Backpressure: stall in HOLD after 8 bytes.
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'(i + 8'h20));
    repeat (20) @(posedge rclk);
    #1;
    chk("hold_left_in_fifo", fifo.size(), 4);
    chk("hold_valid", m_valid, 1);
    m_ready = 1'b1;
    wait_drain(100);

    // Partial flush.
    push(8'hA1); push(8'hA2);
    wait_drain(50);
    pulse_flush();
    wait_drain(50);
    chk("fd_count_a", fd_cnt, exp_fd);

    // Full word then partial via flush.
    for (int i = 0; i < 6; i++) push(8'(i + 8'h50));
    wait_drain(50);
    pulse_flush();
    wait_drain(50);
    chk("fd_count_b", fd_cnt, exp_fd);

    // Flush while the output register is busy.
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(8'(i + 8'hC0));
    repeat (15) @(posedge rclk);
    pulse_flush();
    repeat (5) @(posedge rclk);
    #1;
    m_ready = 1'b1;
    wait_drain(50);
    chk("fd_count_c", fd_cnt, exp_fd);

    // Flush with nothing held.
    @(posedge rclk); #1;
    flush = 1'b1;
    flush_model();
    @(posedge rclk); #1;
    flush = 1'b0;
    @(negedge rclk);
    chk("fd_empty_next", flush_done, 1);
    chk("fd_empty_novalid", m_valid, 0);
    @(negedge rclk);
    chk("fd_empty_single", flush_done, 0);
    wait_drain(20);
    chk("fd_count_d", fd_cnt, exp_fd);

`ifdef FIFO_RD_PACK_TIMEOUT_EN
    push(8'h99);
    flush_model();
    wait_drain(80);
    chk("fd_count_tmo", fd_cnt, exp_fd);
`else
    push(8'h99);
    repeat (40) @(posedge rclk);
    #1;
    chk("no_autoflush", m_valid, 0);
    chk("no_autoflush_q", exp_q.size(), 0);
    pulse_flush();
    wait_drain(50);
    chk("fd_count_tmo", fd_cnt, exp_fd);
`endif

    // Reset mid-word with a word waiting at the output.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(i + 8'h60));
    repeat (12) @(posedge rclk);
    #1;
    chk("pre_rst_valid", m_valid, 1);
    @(posedge rclk); #2;
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_rd", rd, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_keep", m_keep, 0);
    chk("mid_rst_last", m_last, 0);
    exp_q.delete();
    fifo.delete();
    acc_n = 0;
    empty = 1'b1;
    repeat (2) @(posedge rclk);
    #1;
    for (int i = 0; i < 4; i++) push(8'(i + 8'h70));
    @(posedge rclk); #2;
    rrst_n = 1'b1;
    @(negedge rclk);
    chk("rd_first_edge", rd, 0);
    @(negedge rclk);
    chk("rd_after_first", rd, 1);
    m_ready = 1'b1;
    wait_drain(50);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
